// File: rtl/mem_access_unit.sv
// Data-memory access stage: runs one valid/ready bus transaction per accepted
// load/store, steers store byte lanes, extends load data and stalls the control FSM.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  funct3,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata_out,
    output logic        fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE
    } state_t;

    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_wstrb_q, bus_wstrb_d;
    logic [31:0] rdata_q, rdata_d;
    logic        fault_q, fault_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;

    logic        req_any;
    logic        access_ok;
    logic [31:0] st_data;
    logic [3:0]  st_strb;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    assign req_any = req_read | req_write;

    // funct3[1:0] gives the access size for both loads and stores.
    always_comb begin
        access_ok = 1'b1;
        if (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7) begin
            access_ok = 1'b0;
        end else if (funct3[1:0] == 2'd1 && addr[0]) begin
            access_ok = 1'b0;
        end else if (funct3[1:0] == 2'd2 && addr[1:0] != 2'd0) begin
            access_ok = 1'b0;
        end
    end

    always_comb begin
        case (funct3[1:0])
            2'd0: begin
                st_data = {4{wdata[7:0]}};
                st_strb = 4'b0001 << addr[1:0];
            end
            2'd1: begin
                st_data = {2{wdata[15:0]}};
                st_strb = addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_data = wdata;
                st_strb = 4'b1111;
            end
        endcase
    end

    // Lane selection uses the offset and size captured at accept, not the live inputs.
    always_comb begin
        case (off_q)
            2'd0:    ld_byte = bus_rdata[7:0];
            2'd1:    ld_byte = bus_rdata[15:8];
            2'd2:    ld_byte = bus_rdata[23:16];
            default: ld_byte = bus_rdata[31:24];
        endcase
        ld_half = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (f3_q)
            3'd0:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'd4:    ld_ext = {24'd0, ld_byte};
            3'd1:    ld_ext = {{16{ld_half[15]}}, ld_half};
            3'd5:    ld_ext = {16'd0, ld_half};
            default: ld_ext = bus_rdata;
        endcase
    end

    // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_wstrb_d = bus_wstrb_q;
        rdata_d     = rdata_q;
        fault_d     = fault_q;
        cnt_d       = cnt_q;
        f3_d        = f3_q;
        off_d       = off_q;

        case (state_q)
            S_IDLE: begin
                if (req_any) begin
                    if (access_ok) begin
                        bus_addr_d  = {addr[31:2], 2'b00};
                        bus_we_d    = req_write;
                        bus_wdata_d = req_write ? st_data : 32'd0;
                        bus_wstrb_d = req_write ? st_strb : 4'd0;
                        f3_d        = funct3;
                        off_d       = addr[1:0];
                        bus_req_d   = 1'b1;
                        cnt_d       = 16'd0;
                        state_d     = S_REQ;
                    end else begin
                        fault_d = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_REQ: begin
                if (bus_ready) begin
                    bus_req_d = 1'b0;
                    if (!bus_we_q) begin
                        rdata_d = ld_ext;
                    end
                    state_d = S_DONE;
                end else if (cnt_q + 16'd1 == TIMEOUT_LIMIT) begin
                    bus_req_d = 1'b0;
                    fault_d   = 1'b1;
                    rdata_d   = 32'd0;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DONE: begin
                cnt_d   = 16'd0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_wdata_q <= 32'd0;
            bus_wstrb_q <= 4'd0;
            rdata_q     <= 32'd0;
            fault_q     <= 1'b0;
            cnt_q       <= 16'd0;
            f3_q        <= 3'd0;
            off_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_wstrb_q <= bus_wstrb_d;
            rdata_q     <= rdata_d;
            fault_q     <= fault_d;
            cnt_q       <= cnt_d;
            f3_q        <= f3_d;
            off_q       <= off_d;
        end
    end

    assign busy      = (state_q == S_IDLE && req_any) || state_q == S_REQ;
    assign done      = (state_q == S_DONE);
    assign rdata_out = rdata_q;
    assign fault     = fault_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_wstrb = bus_wstrb_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Data-memory access stage directly downstream of the multicycle control FSM.
- Consumes mem_read/mem_write from the MEM_RD/MEM_WR states, plus the ALUOut address, register-B store data and funct3.
- Runs a valid/ready transaction on the data bus with byte-lane steering and load sign/zero extension.
- Holds the loaded word for the WB_MEM state and raises busy so the control FSM stalls until the access completes.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles bus_req may stay high without bus_ready before the access aborts (1..65535).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- req_read  in  1  load request (level; control unit mem_read)
- req_write  in  1  store request (level; control unit mem_write)
- addr  in  32  byte address (ALUOut)
- wdata  in  32  store data (register B)
- funct3  in  3  access size/sign: 0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU
- busy  out  1  stall; the control FSM holds its state while 1
- done  out  1  one-cycle completion pulse
- rdata_out  out  32  extended load result (MDR)
- fault  out  1  sticky: misaligned, illegal funct3 or timeout
- bus_req  out  1  bus valid
- bus_we  out  1  1 = write
- bus_addr  out  32  word-aligned address {addr[31:2],2'b00}
- bus_wdata  out  32  lane-steered store data
- bus_wstrb  out  4  byte enables (0000 on reads)
- bus_ready  in  1  slave accept/complete
- bus_rdata  in  32  read data, valid when bus_ready=1 on a read

Behaviour:
- Reset values: state IDLE; busy combinational (0 once req lines are low); done=0, rdata_out=0, fault=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_wstrb=0, timeout counter=0.
- Reset at any clock edge, including mid-transaction, clears all state. bus_req is 0 in the following cycle. No completion is reported.
- Request handling:
  - Accepted only in IDLE when req_read|req_write.
  - If both are high, the write wins.
  - Requests seen in REQ or DONE are ignored.
- busy = (IDLE & (req_read|req_write)) | REQ. It is 0 in DONE.
- IDLE accept, legal access:
  - Register bus_addr, bus_we, bus_wdata and bus_wstrb.
  - Set bus_req=1 and move to REQ.
- IDLE accept, illegal access:
  - Illegal means funct3 in {3,6,7}; halfword with addr[0]=1; or word with addr[1:0]!=0.
  - No bus transaction. fault<=1, go to DONE, rdata_out unchanged.
- REQ:
  - All bus_* outputs are held stable.
  - bus_ready=1 at an edge: bus_req<=0; on a read, rdata_out<=extended bus_rdata; go to DONE.
  - Otherwise increment the counter. When it reaches TIMEOUT_CYCLES: bus_req<=0, fault<=1, rdata_out<=0, go to DONE.
- DONE: done=1 for exactly one cycle, counter cleared, unconditionally returns to IDLE.
- Latency: request cycle N, bus_req from N+1; bus_ready at N+1+k gives done at N+2+k. Zero-wait bus: done at N+2.
- Store steering:
  - SB: bus_wdata={4{wdata[7:0]}}, bus_wstrb=0001<<addr[1:0].
  - SH: bus_wdata={2{wdata[15:0]}}, bus_wstrb=0011 (addr[1]=0) or 1100 (addr[1]=1).
  - SW: bus_wdata=wdata, bus_wstrb=1111.
- Load extraction:
  - Byte select by addr[1:0]; halfword select by addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - addr[1:0] is captured at accept.
- rdata_out holds its value until the next successful load.
- fault stays set until reset and does not block later accesses.

Test Plan:
- LW, addr=0x100, bus_ready after 2 wait cycles, bus_rdata=0xDEADBEEF -> bus_addr=0x100, bus_we=0; busy high 4 cycles; done at request+4; rdata_out=0xDEADBEEF.
- LB addr=0x203, bus_rdata=0x80FF1234 (zero-wait) -> rdata_out=0xFFFFFF80. LBU same -> 0x00000080. LHU addr=0x202 -> 0x000080FF.
- SB addr=0x11, wdata=0x000000A5 -> bus_addr=0x10, bus_wstrb=0010, bus_wdata=0xA5A5A5A5, bus_we=1. SH addr=0x12, wdata=0x1234 -> bus_wstrb=1100, bus_wdata=0x12341234.
- LH addr=0x101 -> bus_req never asserted; done one cycle after request; fault=1; rdata_out unchanged. A following aligned LW still completes normally.
- TIMEOUT_CYCLES=4, LW with bus_ready tied 0 -> bus_req high exactly 4 cycles then drops; fault=1, rdata_out=0, done pulses once.
- Reset asserted on the 2nd wait cycle of an SW -> bus_req=0 the next cycle; done never pulses; all outputs at reset values; a new LW then completes normally.
